// File: rtl/timer_apb_slave.sv
// APB register slave for the timer block: data, control, status and counter
// readback registers behind an IDLE/SETUP/ACCESS handshake with programmable waits.
module timer_apb_slave #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [7:0]  RESET_TDR   = 8'h00
) (
   input  logic       pclk,
   input  logic       presetn,
   input  logic       psel,
   input  logic       penable,
   input  logic       pwrite,
   input  logic [7:0] paddr,
   input  logic [7:0] pwdata,
   output logic [7:0] prdata,
   output logic       pready,
   output logic       pslverr,
   input  logic       ovf_set,
   input  logic       udf_set,
   input  logic [7:0] tcnt,
   output logic [7:0] tdr,
   output logic       tcr_load,
   output logic       tcr_down,
   output logic       tcr_en,
   output logic [1:0] tcr_cks
);

   localparam int unsigned     CNT_W     = 2;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);
   localparam logic [7:0]      TCR_MASK  = 8'hB3;

   localparam logic [7:0] ADDR_TDR  = 8'h00;
   localparam logic [7:0] ADDR_TCR  = 8'h01;
   localparam logic [7:0] ADDR_TSR  = 8'h02;
   localparam logic [7:0] ADDR_TCNT = 8'h03;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wcnt_q, wcnt_d;
   logic [7:0]       tdr_q, tdr_d;
   logic [7:0]       tcr_q, tcr_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;

   logic             done_c;
   logic             addr_err_c;
   logic             wr_commit_c;
   logic [7:0]       rd_mux_c;

   // Completion cycle: last ACCESS wait slot with the slave still selected
   assign done_c      = (state_q == ST_ACCESS) && (wcnt_q == WAIT_LAST) && psel;
   assign addr_err_c  = (paddr > ADDR_TCNT) || ((paddr == ADDR_TCNT) && pwrite);
   assign wr_commit_c = done_c && pwrite && !addr_err_c;

   // Handshake FSM next-state and wait counter
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         ST_IDLE: begin
            wcnt_d = '0;
            if (psel && !penable) begin
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            wcnt_d  = '0;
            state_d = psel ? ST_ACCESS : ST_IDLE;
         end
         ST_ACCESS: begin
            if (!psel) begin
               state_d = ST_IDLE;
               wcnt_d  = '0;
            end else if (wcnt_q != WAIT_LAST) begin
               wcnt_d = wcnt_q + CNT_W'(1);
            end else begin
               wcnt_d  = '0;
               state_d = penable ? ST_IDLE : ST_SETUP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            wcnt_d  = '0;
         end
      endcase
   end

   // Register file updates; a flag set pulse overrides a clearing write
   always_comb begin
      tdr_d = tdr_q;
      tcr_d = tcr_q;
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (wr_commit_c) begin
         case (paddr)
            ADDR_TDR: tdr_d = pwdata;
            ADDR_TCR: tcr_d = pwdata & TCR_MASK;
            ADDR_TSR: begin
               ovf_d = ovf_q & pwdata[0];
               udf_d = udf_q & pwdata[1];
            end
            default: ;
         endcase
      end
      if (ovf_set) begin
         ovf_d = 1'b1;
      end
      if (udf_set) begin
         udf_d = 1'b1;
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q <= ST_IDLE;
         wcnt_q  <= '0;
         tdr_q   <= RESET_TDR;
         tcr_q   <= 8'h00;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         tdr_q   <= tdr_d;
         tcr_q   <= tcr_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Read data selection
   always_comb begin
      rd_mux_c = 8'h00;
      case (paddr)
         ADDR_TDR:  rd_mux_c = tdr_q;
         ADDR_TCR:  rd_mux_c = tcr_q;
         ADDR_TSR:  rd_mux_c = {6'b0, udf_q, ovf_q};
         ADDR_TCNT: rd_mux_c = tcnt;
         default:   rd_mux_c = 8'h00;
      endcase
   end

   // Response outputs are quiet outside the completion cycle
   assign pready  = done_c;
   assign pslverr = done_c && addr_err_c;
   assign prdata  = (done_c && !pwrite && !addr_err_c) ? rd_mux_c : 8'h00;

   assign tdr      = tdr_q;
   assign tcr_load = tcr_q[7];
   assign tcr_down = tcr_q[5];
   assign tcr_en   = tcr_q[4];
   assign tcr_cks  = tcr_q[1:0];

endmodule

// File: tb/tb_timer_apb_slave.sv
// Self-checking bench for timer_apb_slave: directed register scenarios plus
// randomized transfers scored against a register-level reference model.
module tb_timer_apb_slave;

   logic       pclk = 1'b0;
   logic       presetn;
   logic       psel, penable, pwrite;
   logic [7:0] paddr, pwdata, tcnt;
   logic       ovf_set, udf_set;
   logic       sel_b;

   logic       psel_a, psel_b;
   logic [7:0] prdata_a, prdata_b, tdr_a, tdr_b;
   logic       pready_a, pready_b, pslverr_a, pslverr_b;
   logic       load_a, down_a, en_a, load_b, down_b, en_b;
   logic [1:0] cks_a, cks_b;

   logic       obs_pready, obs_pslverr;
   logic [7:0] obs_prdata;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [7:0] m_tdr, m_tcr, m_tdr_b;
   logic       m_ovf, m_udf;

   always #5 pclk = ~pclk;

   assign psel_a      = psel & ~sel_b;
   assign psel_b      = psel & sel_b;
   assign obs_pready  = sel_b ? pready_b  : pready_a;
   assign obs_pslverr = sel_b ? pslverr_b : pslverr_a;
   assign obs_prdata  = sel_b ? prdata_b  : prdata_a;

   timer_apb_slave #(.WAIT_CYCLES(1), .RESET_TDR(8'h00)) dut_a (
      .pclk(pclk), .presetn(presetn), .psel(psel_a), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a),
      .pready(pready_a), .pslverr(pslverr_a), .ovf_set(ovf_set), .udf_set(udf_set),
      .tcnt(tcnt), .tdr(tdr_a), .tcr_load(load_a), .tcr_down(down_a),
      .tcr_en(en_a), .tcr_cks(cks_a)
   );

   timer_apb_slave #(.WAIT_CYCLES(3), .RESET_TDR(8'h00)) dut_b (
      .pclk(pclk), .presetn(presetn), .psel(psel_b), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b),
      .pready(pready_b), .pslverr(pslverr_b), .ovf_set(ovf_set), .udf_set(udf_set),
      .tcnt(tcnt), .tdr(tdr_b), .tcr_load(load_b), .tcr_down(down_b),
      .tcr_en(en_b), .tcr_cks(cks_b)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] exp_rd(input logic b, input logic [7:0] a);
      if (b) return (a == 8'h00) ? m_tdr_b : 8'h00;
      case (a)
         8'h00:   return m_tdr;
         8'h01:   return m_tcr;
         8'h02:   return {6'b0, m_udf, m_ovf};
         8'h03:   return tcnt;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_reset();
      m_tdr = 8'h00; m_tcr = 8'h00; m_tdr_b = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_tdr"}, tdr_a, m_tdr);
      check({tag, "_tcr"}, {load_a, down_a, en_a, cks_a},
            {m_tcr[7], m_tcr[5], m_tcr[4], m_tcr[1:0]});
      check({tag, "_tdr_b"}, tdr_b, m_tdr_b);
   endtask

   // One complete transfer; optional flag pulses land in the completion cycle
   task automatic xfer(input logic b, input logic wr, input logic [7:0] addr, input logic [7:0] data,
                       input logic p_ovf, input logic p_udf, output logic [7:0] rdata);
      int         lat;
      logic       done;
      logic       err_exp;
      logic [7:0] rd_exp;
      err_exp = (addr > 8'h03) || ((addr == 8'h03) && wr);
      rdata   = 8'h00;
      @(negedge pclk);
      sel_b = b; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
      @(negedge pclk);
      penable = 1'b1;
      lat = 1;
      done = 1'b0;
      while (!done && lat < 12) begin
         @(negedge pclk);
         lat++;
         if (obs_pready) done = 1'b1;
         else begin
            check("wait_prdata", obs_prdata, 8'h00);
            check("wait_pslverr", obs_pslverr, 1'b0);
         end
      end
      check("pready_seen", done, 1'b1);
      if (done) begin
         rd_exp = exp_rd(b, addr);
         rdata  = obs_prdata;
         check("latency", lat, b ? 5 : 3);
         check("pslverr", obs_pslverr, err_exp);
         if (!wr || err_exp) check("prdata", obs_prdata, err_exp ? 8'h00 : rd_exp);
         ovf_set = p_ovf;
         udf_set = p_udf;
      end
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0; ovf_set = 1'b0; udf_set = 1'b0;
      if (done && wr && !err_exp) begin
         if (b) begin
            if (addr == 8'h00) m_tdr_b = data;
         end else begin
            case (addr)
               8'h00: m_tdr = data;
               8'h01: m_tcr = data & 8'hB3;
               8'h02: begin m_ovf = m_ovf & data[0]; m_udf = m_udf & data[1]; end
               default: ;
            endcase
         end
      end
      if (done && p_ovf) m_ovf = 1'b1;
      if (done && p_udf) m_udf = 1'b1;
      check_regs("post");
   endtask

   task automatic pulse(input logic o, input logic u);
      @(negedge pclk);
      ovf_set = o; udf_set = u;
      @(negedge pclk);
      ovf_set = 1'b0; udf_set = 1'b0;
      if (o) m_ovf = 1'b1;
      if (u) m_udf = 1'b1;
   endtask

   initial begin
      logic [7:0] rd;
      logic [7:0] ra, rdat;
      logic       rw, ro, ru;

      presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 8'h00; pwdata = 8'h00; tcnt = 8'h3C; ovf_set = 1'b0; udf_set = 1'b0; sel_b = 1'b0;
      model_reset();
      repeat (3) @(negedge pclk);
      check("rst_tdr", tdr_a, 8'h00);
      check("rst_tdr_b", tdr_b, 8'h00);
      check("rst_tcr", {load_a, down_a, en_a, cks_a}, 5'b0);
      check("rst_pready", pready_a, 1'b0);
      check("rst_prdata", prdata_a, 8'h00);
      check("rst_pslverr", pslverr_a, 1'b0);
      presetn = 1'b1;

      xfer(0, 0, 8'h02, 8'h00, 0, 0, rd);
      check("rst_tsr", rd, 8'h00);

      // Control register basics
      xfer(0, 1, 8'h01, 8'h10, 0, 0, rd);
      xfer(0, 0, 8'h01, 8'h00, 0, 0, rd);
      check("tcr_rd10", rd, 8'h10);
      check("tcr_en", en_a, 1'b1);
      check("tcr_down", down_a, 1'b0);
      check("tcr_cks", cks_a, 2'b00);
      check("tcr_load", load_a, 1'b0);
      xfer(0, 1, 8'h01, 8'hFF, 0, 0, rd);
      xfer(0, 0, 8'h01, 8'h00, 0, 0, rd);
      check("tcr_rdB3", rd, 8'hB3);

      // Sticky status flags, write-zero-to-clear, set beats clear
      pulse(1, 0);
      xfer(0, 0, 8'h02, 8'h00, 0, 0, rd);
      check("tsr_ovf", rd, 8'h01);
      xfer(0, 1, 8'h02, 8'h00, 0, 0, rd);
      xfer(0, 0, 8'h02, 8'h00, 0, 0, rd);
      check("tsr_clr", rd, 8'h00);
      xfer(0, 1, 8'h02, 8'h00, 0, 1, rd);
      xfer(0, 0, 8'h02, 8'h00, 0, 0, rd);
      check("tsr_setwins", rd, 8'h02);

      // Error responses
      xfer(0, 0, 8'h05, 8'h00, 0, 0, rd);
      check("err_rd05", rd, 8'h00);
      tcnt = 8'h96;
      xfer(0, 1, 8'h03, 8'h55, 0, 0, rd);
      xfer(0, 0, 8'h03, 8'h00, 0, 0, rd);
      check("tcnt_rd", rd, 8'h96);

      // penable without a setup phase is ignored
      @(negedge pclk);
      sel_b = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h77;
      repeat (4) begin
         @(negedge pclk);
         check("noset_rdy", pready_a, 1'b0);
      end
      psel = 1'b0; penable = 1'b0;
      @(negedge pclk);
      check("noset_tdr", tdr_a, m_tdr);

      // Abort from SETUP and from ACCESS
      @(negedge pclk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hEE;
      @(negedge pclk);
      psel = 1'b0;
      repeat (3) begin
         @(negedge pclk);
         check("abort_s_rdy", pready_a, 1'b0);
      end
      check("abort_s_tdr", tdr_a, m_tdr);
      @(negedge pclk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hDD;
      @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0;
      repeat (3) begin
         @(negedge pclk);
         check("abort_a_rdy", pready_a, 1'b0);
      end
      check("abort_a_tdr", tdr_a, m_tdr);

      // Randomized traffic against the model
      for (int i = 0; i < 80; i++) begin
         ra = 8'($urandom_range(0, 5));
         if ($urandom_range(0, 9) == 0) ra = 8'($urandom_range(4, 255));
         rw   = 1'($urandom_range(0, 1));
         rdat = 8'($urandom);
         ro   = ($urandom_range(0, 3) == 0);
         ru   = ($urandom_range(0, 3) == 0);
         tcnt = 8'($urandom);
         if ($urandom_range(0, 4) == 0) pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         xfer(0, rw, ra, rdat, ro, ru, rd);
      end

      // Three-wait instance
      xfer(1, 1, 8'h00, 8'h5A, 0, 0, rd);
      xfer(1, 0, 8'h00, 8'h00, 0, 0, rd);
      check("b_rd5A", rd, 8'h5A);

      // Reset during ACCESS discards the write and ignores flag pulses
      @(negedge pclk);
      sel_b = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hA5;
      @(negedge pclk);
      penable = 1'b1;
      repeat (2) @(negedge pclk);
      check("rst_mid_pre", pready_b, 1'b0);
      presetn = 1'b0;
      ovf_set = 1'b1;
      #1;
      check("rst_mid_rdy", pready_b, 1'b0);
      check("rst_mid_tdr", tdr_b, 8'h00);
      model_reset();
      repeat (2) @(negedge pclk);
      ovf_set = 1'b0;
      presetn = 1'b1;
      repeat (6) begin
         @(negedge pclk);
         check("rst_post_rdy", pready_b, 1'b0);
      end
      psel = 1'b0; penable = 1'b0;
      @(negedge pclk);
      check("rst_post_tdr", tdr_b, 8'h00);
      check("b_tcr", {load_b, down_b, en_b, cks_b}, 5'b0);
      xfer(0, 0, 8'h02, 8'h00, 0, 0, rd);
      check("rst_tsr_clean", rd, 8'h00);
      xfer(0, 0, 8'h01, 8'h00, 0, 0, rd);
      check("rst_tcr_clean", rd, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/timer_apb_slave.md
TIMER_APB_SLAVE -- requirements
Module: timer_apb_slave

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, meaning: number of ACCESS cycles with pready low before completion (legal 0..3).
REQ-002 Parameter RESET_TDR, default 8'h00, meaning: reset value of TDR.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 pclk  input  1  APB clock; all state updates on rising edge.
REQ-005 presetn  input  1  asynchronous active-low reset.
REQ-006 psel  input  1  APB select.
REQ-007 penable  input  1  APB enable (access phase).
REQ-008 pwrite  input  1  1 = write, 0 = read.
REQ-009 paddr  input  8  register address.
REQ-010 pwdata  input  8  write data.
REQ-011 prdata  output  8  read data, valid only in the cycle pready=1.
REQ-012 pready  output  1  transfer completion.
REQ-013 pslverr  output  1  transfer error, valid only with pready=1.
REQ-014 ovf_set  input  1  one-cycle pulse from the counter core: overflow occurred.
REQ-015 udf_set  input  1  one-cycle pulse from the counter core: underflow occurred.
REQ-016 tcnt  input  8  current counter value from the counter core.
REQ-017 tdr  output  8  TDR register contents.
REQ-018 tcr_load  output  1  TCR[7].
REQ-019 tcr_down  output  1  TCR[5]; 0 = count up.
REQ-020 tcr_en  output  1  TCR[4].
REQ-021 tcr_cks  output  2  TCR[1:0] clock select; 00 = pclk/2.

Function
REQ-022 The FSM SHALL have states IDLE, SETUP and ACCESS.
- IDLE->SETUP on psel=1, penable=0.
- SETUP->ACCESS on the next cycle.
- ACCESS holds while the wait counter is below WAIT_CYCLES, then drives pready=1 for exactly one cycle and returns to IDLE, or to SETUP if psel=1 and penable=0 in that cycle.
REQ-023 penable=1 seen in IDLE without a prior SETUP SHALL be ignored: no pready and no register change.
REQ-024 psel falling to 0 in SETUP or ACCESS SHALL abort the transfer to IDLE with no register change and no pready.
REQ-025 Writes SHALL commit on the rising edge ending the pready=1 cycle, using paddr and pwdata sampled in that cycle.
REQ-026 Transfer latency SHALL be WAIT_CYCLES+2 cycles from the SETUP cycle to the pready cycle, inclusive.
REQ-027 Address map:
- 0x00 TDR: read/write, all 8 bits.
- 0x01 TCR: read/write; bits 7,5,4,1,0 writable; bits 6,3,2 read 0 and ignore writes.
- 0x02 TSR: bit0 OVF, bit1 UDF, bits 7:2 read 0.
- 0x03 TCNT: read-only, returns tcnt.
REQ-028 TSR flags SHALL be sticky: ovf_set=1 sets OVF, and udf_set=1 sets UDF.
REQ-029 A TSR write SHALL clear each flag whose pwdata bit is 0 and leave unchanged each flag whose pwdata bit is 1.
REQ-030 When a set pulse and a clearing write hit the same flag in the same cycle, set SHALL win.
REQ-031 A write to 0x03, or any access to 0x04..0xFF, SHALL give pslverr=1 with pready, prdata=8'h00 and no state change.
REQ-032 prdata and pslverr SHALL be 8'h00 and 0 in every cycle where pready=0.
REQ-033 The TCR outputs and tdr SHALL reflect the register contents combinationally from the registers, with no extra delay after commit.

Reset
REQ-034 presetn=0 SHALL immediately force:
- FSM to IDLE and wait counter to 0;
- TDR to RESET_TDR;
- TCR and TSR to 8'h00;
- pready=0, pslverr=0, prdata=8'h00.
REQ-035 A reset asserted mid-transfer SHALL discard the transfer, and no write SHALL commit.
REQ-036 Flag set pulses arriving while presetn=0 SHALL be ignored.

Verification
REQ-037 Write 0x01<-8'h10, then read 0x01 -> prdata=8'h10; tcr_en=1, tcr_down=0, tcr_cks=00, tcr_load=0.
REQ-038 Write 0x01<-8'hFF -> read returns 8'hB3.
REQ-039 One ovf_set pulse -> read 0x02 = 8'h01. Write 0x02<-8'h00 -> read 0x02 = 8'h00.
REQ-040 udf_set pulse in the same cycle as a committing write 0x02<-8'h00 -> read 0x02 = 8'h02.
REQ-041 Read 0x05 -> pready=1, pslverr=1, prdata=8'h00. Write 0x03<-8'h55 -> pslverr=1, and tcnt readback is unchanged.
REQ-042 With WAIT_CYCLES=3, pready rises 5 cycles after SETUP. Deasserting presetn during ACCESS of a write 0x00<-8'hA5 leaves tdr=8'h00.
